// File: rtl/alu_pkg.sv
// Shared definitions for the keypad-driven ALU experiment: controller state
// codes and the opcode map understood by the ALU datapath.
package alu_pkg;

   typedef enum logic [2:0] {
      ST_ENTER_A  = 3'd0,
      ST_ENTER_B  = 3'd1,
      ST_ENTER_OP = 3'd2,
      ST_EXEC     = 3'd3,
      ST_SHOW     = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_AND    = 4'h2;
   localparam logic [3:0] OP_OR     = 4'h3;
   localparam logic [3:0] OP_XOR    = 4'h4;
   localparam logic [3:0] OP_NOT    = 4'h5;
   localparam logic [3:0] OP_SHL    = 4'h6;
   localparam logic [3:0] OP_SHR    = 4'h7;
   localparam logic [3:0] OP_INC    = 4'h8;
   localparam logic [3:0] OP_DEC    = 4'h9;
   localparam logic [3:0] OP_PASS_A = 4'hA;
   localparam logic [3:0] OP_PASS_B = 4'hB;

endpackage

// File: rtl/hex_shift_reg.sv
// Hex digit entry register: each load shifts one nibble in at the LSB end and
// drops the top nibble. Also exposes the value it will hold after this edge.
module hex_shift_reg
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             load,
   input  logic             clr,
   input  logic [3:0]       nibble_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nxt
);

   logic [WIDTH-1:0] shifted;

   // A single-nibble register simply takes the new digit.
   if (WIDTH > 4) begin : g_wide
      assign shifted = {q[WIDTH-5:0], nibble_in};
   end else begin : g_narrow
      assign shifted = nibble_in;
   end

   always_comb begin
      nxt = q;
      if (clr) begin
         nxt = '0;
      end else if (load) begin
         nxt = shifted;
      end
   end

   always_ff @(posedge clk) begin
      q <= nxt;
   end

endmodule

// File: rtl/alu_entry_ctrl.sv
// Keypad sequencer for the ALU experiment: collects A, B and opcode, issues a
// single ALU request with timeout, and drives the seven-segment display word.
module alu_entry_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   input  logic             enter,
   input  logic             cancel,
   output logic             alu_req,
   input  logic             alu_ack,
   input  logic [WIDTH-1:0] alu_res,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] result,
   output logic [15:0]      disp,
   output logic [2:0]       state_o,
   output logic             err
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [15:0]      cnt, cnt_nxt;
   logic [3:0]       op_nxt;
   logic [WIDTH-1:0] res_nxt, a_nxt, b_nxt;
   logic             err_nxt;
   logic             a_ld, b_ld, f_clr;
   logic [15:0]      disp_nxt;

   function automatic logic [15:0] fit16(input logic [WIDTH-1:0] v);
      logic [31:0] w;
      w = 32'(v);
      return w[15:0];
   endfunction

   hex_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
      .clk       (clk),
      .load      (a_ld),
      .clr       (f_clr | ~clr_n),
      .nibble_in (key_code),
      .q         (op_a),
      .nxt       (a_nxt)
   );

   hex_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
      .clk       (clk),
      .load      (b_ld),
      .clr       (f_clr | ~clr_n),
      .nibble_in (key_code),
      .q         (op_b),
      .nxt       (b_nxt)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      op_nxt    = alu_op;
      res_nxt   = result;
      err_nxt   = err;
      a_ld      = 1'b0;
      b_ld      = 1'b0;
      f_clr     = 1'b0;
      if (cancel) begin
         state_nxt = ST_ENTER_A;
         f_clr     = 1'b1;
         op_nxt    = '0;
         res_nxt   = '0;
         err_nxt   = 1'b0;
      end else begin
         case (state)
            ST_ENTER_A: begin
               if (enter)          state_nxt = ST_ENTER_B;
               else if (key_valid) a_ld      = 1'b1;
            end
            ST_ENTER_B: begin
               if (enter)          state_nxt = ST_ENTER_OP;
               else if (key_valid) b_ld      = 1'b1;
            end
            ST_ENTER_OP: begin
               if (enter)          state_nxt = ST_EXEC;
               else if (key_valid) op_nxt    = key_code;
            end
            ST_EXEC: begin
               // An ack arriving on the last allowed cycle still counts.
               if (alu_ack) begin
                  res_nxt   = alu_res;
                  state_nxt = ST_SHOW;
               end else if (cnt == TMO_LAST) begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_SHOW;
               end else begin
                  cnt_nxt   = cnt + 16'd1;
               end
            end
            ST_SHOW: begin
               if (enter) begin
                  state_nxt = ST_ENTER_A;
                  f_clr     = 1'b1;
                  op_nxt    = '0;
                  err_nxt   = 1'b0;
               end
            end
            default: state_nxt = ST_ENTER_A;
         endcase
      end
   end

   // Display follows the values the registers are about to take.
   always_comb begin
      disp_nxt = '0;
      case (state_nxt)
         ST_ENTER_A:  disp_nxt = fit16(a_nxt);
         ST_ENTER_B:  disp_nxt = fit16(b_nxt);
         ST_ENTER_OP: disp_nxt = {12'h000, op_nxt};
         ST_SHOW:     disp_nxt = fit16(res_nxt);
         default:     disp_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state  <= ST_ENTER_A;
         cnt    <= '0;
         alu_op <= '0;
         result <= '0;
         err    <= 1'b0;
         disp   <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         alu_op <= op_nxt;
         result <= res_nxt;
         err    <= err_nxt;
         disp   <= disp_nxt;
      end
   end

   assign alu_req = (state == ST_EXEC);
   assign state_o = state;

endmodule

// File: doc/alu_entry_ctrl.md
Name: alu_entry_ctrl

Overview:
- Sequences keypad-driven operation of the ALU experiment.
- Collects hex operand A, operand B and a 4-bit opcode from decoded key events, then issues one request to the ALU and latches the returned result.
- Drives the 16-bit display word for the seven-segment driver.
- Sits between the keypad scanner/debouncer (one pulse per keypress) and the ALU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4, range 4..32.
- TIMEOUT, 255, maximum cycles to wait for alu_ack after raising alu_req; range 1..65535.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  synchronous active-low reset.
- key_valid  in  1  one-cycle pulse: new hex key in key_code.
- key_code  in  4  hex value of pressed key (0..F).
- enter  in  1  one-cycle pulse: accept current field / advance.
- cancel  in  1  one-cycle pulse: abort, clear all fields.
- alu_req  out  1  request to ALU; level, held until ack or timeout.
- alu_ack  in  1  one-cycle pulse from ALU: result valid this cycle.
- alu_res  in  WIDTH  ALU result, sampled only when alu_ack=1 and alu_req=1.
- op_a  out  WIDTH  operand A to ALU.
- op_b  out  WIDTH  operand B to ALU.
- alu_op  out  4  opcode to ALU.
- result  out  WIDTH  latched ALU result.
- disp  out  16  display word: low 16 bits of the field selected by state.
- state_o  out  3  current state code for LEDs.
- err  out  1  sticky timeout flag, cleared on cancel or entering ENTER_A.

Behaviour:
- Reset (clr_n=0 at posedge): state=ENTER_A; op_a, op_b, alu_op, result, disp = 0; alu_req=0; err=0; wait counter=0.
- States (state_o encoding): ENTER_A=0, ENTER_B=1, ENTER_OP=2, EXEC=3, SHOW=4; codes 5..7 are unused and go to ENTER_A.
- Input priority per cycle: cancel > enter > key_valid. Lower-priority inputs in the same cycle are ignored.
- cancel in any state: next state ENTER_A; clear op_a, op_b, alu_op, result, err; alu_req=0.
- ENTER_A, key_valid: op_a <= {op_a[WIDTH-5:0], key_code}. The MSB nibble is discarded on overflow. enter -> ENTER_B.
- ENTER_B: same shift rule into op_b. enter -> ENTER_OP.
- ENTER_OP, key_valid: alu_op <= key_code (last key wins). enter -> EXEC.
- EXEC:
  - alu_req=1 from the first EXEC cycle. Operands and opcode are stable throughout EXEC.
  - alu_ack=1: result <= alu_res; alu_req=0 next cycle; -> SHOW.
  - Wait counter increments each EXEC cycle without ack. On reaching TIMEOUT: err=1, result unchanged, alu_req=0, -> SHOW.
  - alu_ack on the same cycle as the counter reaching TIMEOUT: ack wins, err stays 0.
  - key_valid and enter are ignored in EXEC; cancel aborts.
- SHOW: key_valid ignored. enter -> ENTER_A: clear op_a, op_b, alu_op and err; result is retained.
- alu_ack outside EXEC is ignored.
- disp is registered and updated each cycle from the next-state values:
  - ENTER_A shows op_a[15:0].
  - ENTER_B shows op_b[15:0].
  - ENTER_OP shows {12'h000, alu_op}.
  - EXEC shows 16'h0000.
  - SHOW shows result[15:0].
  - If WIDTH<16, zero-extend.
- Latency: a key press is visible on disp one cycle after the key_valid pulse. alu_req rises one cycle after the enter that leaves ENTER_OP.
- Reset mid-EXEC: alu_req=0 at that edge; no result captured.

Decomposition:
- Shared package alu_pkg holds the state encodings (ST_ENTER_A..ST_SHOW) and the 4-bit ALU opcode constants, shared with the ALU.
- One natural sub-module: hex_shift_reg (parameter WIDTH; ports load, clr, nibble_in, q), instantiated for op_a and op_b.
- The FSM, wait counter and display mux stay in alu_entry_ctrl.

Test Plan:
- Basic operation: keys 1,2,3,4, enter, keys A,B, enter, key 3, enter, ALU acks 3 cycles after req with alu_res=16'h12F9 -> op_a=16'h1234, op_b=16'h00AB, alu_op=3, alu_req high exactly 3 cycles, result=16'h12F9, disp=16'h12F9, state_o=4.
- Overflow: 5 digits 1,2,3,4,5 in ENTER_A -> op_a=16'h2345.
- Timeout: TIMEOUT=8, no ack -> alu_req drops after 8 cycles, err=1, state_o=4, result unchanged.
- Ack/timeout race: ack on the 8th cycle -> err=0, result captured.
- Simultaneous inputs:
  - key_valid+enter in ENTER_A -> key ignored, state_o=1.
  - cancel+enter in ENTER_B -> state_o=0, all fields 0.
- Reset during EXEC: assert clr_n=0 with alu_req high -> next edge alu_req=0, state_o=0, all outputs 0; stray alu_ack afterward has no effect.
